rv_inst_encoder_packer: RTL and testbench

- Inverse of the dual-slot instruction decode path. Takes decoded-field requests (class, ALU op code, rd/rs1/rs2, immediate) and encodes each into an RV32 instruction word.
- Pairs consecutive instructions, in program order, into 2-wide fetch bundles: slot A takes R, I, BRANCH or JAL; slot B takes R, I, LOAD or STORE.
- Each bundle is emitted with an incrementing instruction-memory address.
- Used by the program loader and by verification stimulus generators.

---
 rtl/rv_inst_encoder_packer.sv | 200 ++++++++++++++++++++
 tb/tb_rv_inst_encoder_packer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_inst_encoder_packer.sv
// Encodes decoded-field requests into RV32 words and packs them, in program order, into
// 2-wide fetch bundles. Optional macro PACK_TIMEOUT_EN closes half-filled bundles after TIMEOUT cycles.
module rv_inst_encoder_packer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_class,
    input  logic [3:0]        req_alu_opr,
    input  logic [2:0]        req_sub_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [20:0]       req_imm,
    input  logic              flush,
    output logic              bundle_valid,
    input  logic              bundle_ready,
    output logic [ADDR_W-1:0] bundle_addr,
    output logic [31:0]       bundle_inst_a,
    output logic [31:0]       bundle_inst_b,
    output logic              hold_valid,
    output logic              err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {EMPTY = 1'b0, HOLD_A = 1'b1} state_t;

    state_t      state;
    logic [31:0] held;
    logic        flush_pending;

    logic [31:0] word;
    logic        illegal, is_ctrl, is_mem;
    logic [2:0]  alu_f3, ld_f3;
    logic        alu_alt;
    logic [11:0] i_imm;
    logic        slot_free, pend, flush_emit, accept, tmo_flush;

    // Shared funct3 for R and I forms; alu_alt selects the SUB/SRA funct7.
    always_comb begin
        alu_f3  = 3'b000;
        alu_alt = 1'b0;
        case (req_alu_opr)
            4'b0001: alu_alt = 1'b1;
            4'b0010: alu_f3  = 3'b001;
            4'b0011: alu_f3  = 3'b100;
            4'b0100: alu_f3  = 3'b101;
            4'b0101: begin alu_f3 = 3'b101; alu_alt = 1'b1; end
            4'b0110: alu_f3  = 3'b110;
            4'b0111: alu_f3  = 3'b111;
            4'b1000: alu_f3  = 3'b010;
            default: alu_f3  = 3'b000;
        endcase
    end

    always_comb begin
        ld_f3 = 3'b000;
        case (req_sub_op)
            3'b001:  ld_f3 = 3'b001;
            3'b010:  ld_f3 = 3'b010;
            3'b011:  ld_f3 = 3'b100;
            3'b100:  ld_f3 = 3'b101;
            3'b101:  ld_f3 = 3'b011;
            default: ld_f3 = 3'b000;
        endcase
    end

    always_comb begin
        word    = NOP;
        illegal = 1'b0;
        is_ctrl = 1'b0;
        is_mem  = 1'b0;
        i_imm   = req_imm[11:0];
        case (req_class)
            3'd0: begin
                illegal = req_alu_opr > 4'd8;
                word    = {(alu_alt ? 7'b0100000 : 7'b0000000), req_rs2, req_rs1, alu_f3,
                           req_rd, 7'b0110011};
            end
            3'd1: begin
                illegal = (req_alu_opr == 4'd1) || (req_alu_opr == 4'd5) || req_alu_opr[3];
                if ((req_alu_opr == 4'd2) || (req_alu_opr == 4'd4))
                    i_imm = {7'b0000000, req_imm[4:0]};
                word    = {i_imm, req_rs1, alu_f3, req_rd, 7'b0010011};
            end
            3'd2: begin
                is_mem  = 1'b1;
                illegal = req_sub_op[2] && req_sub_op[1];
                word    = {req_imm[11:0], req_rs1, ld_f3, req_rd, 7'b0000011};
            end
            3'd3: begin
                is_mem = 1'b1;
                word   = {req_imm[11:5], req_rs2, req_rs1, 1'b0, req_sub_op[1:0], req_imm[4:0],
                          7'b0100011};
            end
            3'd4: begin
                is_ctrl = 1'b1;
                illegal = (req_sub_op == 3'b010) || (req_sub_op == 3'b011);
                word    = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_sub_op,
                           req_imm[4:1], req_imm[11], 7'b1100011};
            end
            3'd5: begin
                is_ctrl = 1'b1;
                word    = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd,
                           7'b1101111};
            end
            default: illegal = 1'b1;
        endcase
    end

    // A pending flush in HOLD_A owns the free output slot, so requests are blocked that cycle.
    assign slot_free  = !bundle_valid || bundle_ready;
    assign pend       = flush_pending || flush || tmo_flush;
    assign flush_emit = pend && (state == HOLD_A) && slot_free;
    assign req_ready  = slot_free && !flush_emit;
    assign accept     = req_valid && req_ready;
    assign hold_valid = (state == HOLD_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            held          <= NOP;
            flush_pending <= 1'b0;
            err           <= 1'b0;
            bundle_valid  <= 1'b0;
            bundle_addr   <= BASE_ADDR;
            bundle_inst_a <= NOP;
            bundle_inst_b <= NOP;
        end else begin
            err <= 1'b0;
            if (bundle_valid && bundle_ready) begin
                bundle_valid <= 1'b0;
                bundle_addr  <= bundle_addr + ADDR_W'(8);
            end
            if (flush_emit) begin
                bundle_valid  <= 1'b1;
                bundle_inst_a <= held;
                bundle_inst_b <= NOP;
                state         <= EMPTY;
                flush_pending <= 1'b0;
            end else if (accept) begin
                flush_pending <= pend;
                if (illegal) begin
                    err <= 1'b1;
                end else if (state == EMPTY) begin
                    if (is_ctrl) begin
                        bundle_valid  <= 1'b1;
                        bundle_inst_a <= word;
                        bundle_inst_b <= NOP;
                    end else if (is_mem) begin
                        bundle_valid  <= 1'b1;
                        bundle_inst_a <= NOP;
                        bundle_inst_b <= word;
                    end else begin
                        held  <= word;
                        state <= HOLD_A;
                    end
                end else begin
                    bundle_valid  <= 1'b1;
                    bundle_inst_a <= held;
                    if (is_ctrl) begin
                        bundle_inst_b <= NOP;
                        held          <= word;
                    end else begin
                        bundle_inst_b <= word;
                        state         <= EMPTY;
                    end
                end
            end else begin
                flush_pending <= pend && (state == HOLD_A);
            end
        end
    end

`ifdef PACK_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       leave_hold;

    assign leave_hold = flush_emit || (accept && !illegal && !is_ctrl);
    assign tmo_flush  = (state == HOLD_A) && (tmo_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if ((state == HOLD_A) && !leave_hold)
            tmo_cnt <= tmo_cnt + 8'd1;
        else
            tmo_cnt <= '0;
    end
`else
    // Without the timeout a held instruction waits for a partner or an explicit flush.
    assign tmo_flush = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_rv_inst_encoder_packer.sv
// Bench for rv_inst_encoder_packer: directed test-plan sequences plus randomized traffic,
// checked against a transaction-level packing model and an expected-bundle queue.
module tb_rv_inst_encoder_packer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_class;
  logic [3:0]  req_alu_opr;
  logic [2:0]  req_sub_op;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [20:0] req_imm;
  logic        flush;
  logic        bundle_valid, bundle_ready;
  logic [31:0] bundle_addr, bundle_inst_a, bundle_inst_b;
  logic        hold_valid, err;

  always #5 clk = ~clk;

  rv_inst_encoder_packer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_alu_opr(req_alu_opr), .req_sub_op(req_sub_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .flush(flush),
    .bundle_valid(bundle_valid), .bundle_ready(bundle_ready), .bundle_addr(bundle_addr),
    .bundle_inst_a(bundle_inst_a), .bundle_inst_b(bundle_inst_b),
    .hold_valid(hold_valid), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int alu_f3 [9] = '{0, 0, 1, 4, 5, 5, 6, 7, 2};
  int ld_f3  [6] = '{0, 1, 2, 4, 5, 3};

  function automatic logic [31:0] enc(int cls, int op, int sub, int rd, int rs1, int rs2, int imm);
    int w, v;
    w = 0;
    case (cls)
      0: w = 'h33 + (rd << 7) + (alu_f3[op] << 12) + (rs1 << 15) + (rs2 << 20)
             + (((op == 1) || (op == 5)) ? (32 << 25) : 0);
      1: begin
        v = ((op == 2) || (op == 4)) ? (imm & 31) : (imm & 'hfff);
        w = 'h13 + (rd << 7) + (alu_f3[op] << 12) + (rs1 << 15) + (v << 20);
      end
      2: w = 'h03 + (rd << 7) + (ld_f3[sub] << 12) + (rs1 << 15) + ((imm & 'hfff) << 20);
      3: w = 'h23 + ((imm & 31) << 7) + ((sub & 3) << 12) + (rs1 << 15) + (rs2 << 20)
             + (((imm >> 5) & 127) << 25);
      4: begin
        v = imm & 'h1ffe;
        w = 'h63 + (((v >> 11) & 1) << 7) + (((v >> 1) & 15) << 8) + (sub << 12) + (rs1 << 15)
            + (rs2 << 20) + (((v >> 5) & 63) << 25) + (((v >> 12) & 1) << 31);
      end
      5: begin
        v = imm & 'h1ffffe;
        w = 'h6f + (rd << 7) + (((v >> 12) & 255) << 12) + (((v >> 11) & 1) << 20)
            + (((v >> 1) & 1023) << 21) + (((v >> 20) & 1) << 31);
      end
      default: w = 0;
    endcase
    return 32'(w);
  endfunction

  function automatic bit is_illegal(int cls, int op, int sub);
    case (cls)
      0: return op > 8;
      1: return (op == 1) || (op == 5) || (op >= 8);
      2: return sub >= 6;
      4: return (sub == 2) || (sub == 3);
      6, 7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // exp_q entry: {flush_tag, slot_a, slot_b}
  logic [64:0] exp_q[$];
  logic [31:0] exp_addr;
  logic [31:0] m_held;
  bit          m_held_v, m_pend, exp_err, acc_last, mon_en, stall_prev;
  int          outstanding;
  logic [31:0] sv_addr, sv_a, sv_b;

  task automatic model_reset();
    exp_q.delete();
    exp_addr = 32'h0; m_held = NOP; m_held_v = 0; m_pend = 0;
    exp_err = 0; acc_last = 0; stall_prev = 0; outstanding = 0;
  endtask

  function automatic void push(logic [31:0] a, logic [31:0] b, bit fl);
    exp_q.push_back({fl, a, b});
  endfunction

  always @(negedge clk) begin
    logic [64:0] e;
    logic [31:0] w;
    int cls, op, sub;
    bit acc, ill;
    if (mon_en) begin
      check("err", err, exp_err);
      if (stall_prev) begin
        check("stall_valid", bundle_valid, 1'b1);
        check("stall_addr", bundle_addr, sv_addr);
        check("stall_inst_a", bundle_inst_a, sv_a);
        check("stall_inst_b", bundle_inst_b, sv_b);
      end
      if (bundle_valid && !bundle_ready) check("req_ready_bp", req_ready, 1'b0);
      if (outstanding == 0) begin
        check("hold_valid", hold_valid, m_held_v);
        if (!bundle_valid && !m_held_v) check("req_ready_idle", req_ready, 1'b1);
      end
      if (bundle_valid && bundle_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_bundle actual=%0h/%0h required=none", bundle_inst_a, bundle_inst_b);
        end else begin
          e = exp_q.pop_front();
          check("bundle_addr", bundle_addr, exp_addr);
          check("bundle_inst_a", bundle_inst_a, e[63:32]);
          check("bundle_inst_b", bundle_inst_b, e[31:0]);
          if (e[64]) outstanding--;
        end
        exp_addr = exp_addr + 32'd8;
      end
      cls = int'(req_class); op = int'(req_alu_opr); sub = int'(req_sub_op);
      acc = req_valid && req_ready;
      ill = is_illegal(cls, op, sub);
      exp_err = acc && ill;
      acc_last = acc;
      if (acc && !ill) begin
        w = enc(cls, op, sub, int'(req_rd), int'(req_rs1), int'(req_rs2), int'($signed(req_imm)));
        if (cls >= 4) begin
          if (m_held_v) begin push(m_held, NOP, 0); m_held = w; end
          else push(w, NOP, 0);
        end else if (m_held_v) begin
          push(m_held, w, 0); m_held_v = 0;
        end else if (cls >= 2) begin
          push(NOP, w, 0);
        end else begin
          m_held = w; m_held_v = 1;
        end
      end
      m_pend = m_pend || flush;
      if (m_pend && !acc) begin
        if (m_held_v) begin push(m_held, NOP, 1); outstanding++; m_held_v = 0; end
        m_pend = 0;
      end
      stall_prev = bundle_valid && !bundle_ready;
      sv_addr = bundle_addr; sv_a = bundle_inst_a; sv_b = bundle_inst_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int cls, input int op, input int sub, input int rd, input int rs1,
                      input int rs2, input int imm);
    bit ok;
    req_class = 3'(cls); req_alu_opr = 4'(op); req_sub_op = 3'(sub);
    req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = 21'(imm);
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=req_ready_low required=accept");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic expect_bundle(input string name, input logic [31:0] addr, input logic [31:0] a,
                               input logic [31:0] b);
    check({name, "_valid"}, bundle_valid, 1'b1);
    check({name, "_addr"}, bundle_addr, addr);
    check({name, "_a"}, bundle_inst_a, a);
    check({name, "_b"}, bundle_inst_b, b);
  endtask

  logic [31:0] bp_addr;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; bundle_ready = 1'b1;
    req_class = '0; req_alu_opr = '0; req_sub_op = '0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    mon_en = 0;
    model_reset();

    // model pins
    check("pin_add",  enc(0, 0, 0, 3, 1, 2, 0),      32'h002081B3);
    check("pin_sub",  enc(0, 1, 0, 3, 1, 2, 0),      32'h402081B3);
    check("pin_lw",   enc(2, 0, 2, 5, 2, 0, 8),      32'h00812283);
    check("pin_beq",  enc(4, 0, 0, 0, 1, 2, 16),     32'h00208863);
    check("pin_addi", enc(1, 0, 0, 1, 0, 0, 5),      32'h00500093);
    check("pin_jal",  enc(5, 0, 0, 1, 0, 0, -4),     32'hFFDFF0EF);
    check("pin_sw",   enc(3, 0, 2, 0, 1, 2, -8),     32'hFE20AC23);
    check("pin_slli", enc(1, 2, 0, 1, 2, 0, 'h7e3),  32'h00311093);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_bundle_valid", bundle_valid, 1'b0);
    check("rst_hold_valid", hold_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_addr", bundle_addr, 32'h0);
    check("rst_inst_a", bundle_inst_a, NOP);
    check("rst_inst_b", bundle_inst_b, NOP);
    check("rst_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1;

    // ADD + LW pair
    send(0, 0, 0, 3, 1, 2, 0);
    send(2, 0, 2, 5, 2, 0, 8);
    @(negedge clk);
    expect_bundle("pair", 32'h0, 32'h002081B3, 32'h00812283);
    @(posedge clk); #1;
    // LW alone
    send(2, 0, 2, 5, 2, 0, 8);
    @(negedge clk);
    expect_bundle("lw_alone", 32'h8, NOP, 32'h00812283);
    check("lw_alone_hold", hold_valid, 1'b0);
    @(posedge clk); #1;
    // SUB then BEQ, then flush
    send(0, 1, 0, 3, 1, 2, 0);
    send(4, 0, 0, 0, 1, 2, 16);
    @(negedge clk);
    expect_bundle("sub_beq", 32'h10, 32'h402081B3, NOP);
    check("sub_beq_hold", hold_valid, 1'b1);
    @(posedge clk); #1;
    pulse_flush();
    @(negedge clk);
    expect_bundle("flush_beq", 32'h18, 32'h00208863, NOP);
    check("flush_beq_hold", hold_valid, 1'b0);
    @(posedge clk); #1;
    // illegal R op
    send(0, 10, 0, 1, 2, 3, 0);
    @(negedge clk);
    check("illegal_err", err, 1'b1);
    check("illegal_no_bundle", bundle_valid, 1'b0);
    @(negedge clk);
    check("illegal_err_clear", err, 1'b0);
    @(posedge clk); #1;
    // illegal while holding keeps the held instruction
    send(1, 0, 0, 1, 0, 0, 5);
    send(7, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("illegal_held_err", err, 1'b1);
    check("illegal_held_hold", hold_valid, 1'b1);
    @(posedge clk); #1;
    send(3, 0, 2, 0, 1, 2, -8);
    @(negedge clk);
    expect_bundle("held_sw", 32'h20, 32'h00500093, 32'hFE20AC23);
    @(posedge clk); #1;
    // backpressure
    bundle_ready = 1'b0;
    send(0, 1, 0, 3, 1, 2, 0);
    send(2, 0, 2, 5, 2, 0, 8);
    @(negedge clk);
    bp_addr = bundle_addr;
    check("bp_addr", bp_addr, 32'h28);
    repeat (5) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_valid", bundle_valid, 1'b1);
      check("bp_inst_a", bundle_inst_a, 32'h402081B3);
    end
    @(posedge clk); #1;
    bundle_ready = 1'b1;
    send(1, 0, 0, 1, 0, 0, 5);
    pulse_flush();
    @(negedge clk);
    expect_bundle("after_bp", bp_addr + 32'd8, 32'h00500093, NOP);
    @(posedge clk); #1;
    // no timeout in the default build
    send(1, 0, 0, 1, 0, 0, 5);
    repeat (30) @(negedge clk);
    check("no_timeout_valid", bundle_valid, 1'b0);
    check("no_timeout_hold", hold_valid, 1'b1);
    @(posedge clk); #1;
    // reset mid-operation
    mon_en = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_hold", hold_valid, 1'b0);
    check("midrst_valid", bundle_valid, 1'b0);
    check("midrst_addr", bundle_addr, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1;

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if (!req_valid || acc_last) begin
        req_valid   = ($urandom_range(0, 3) != 0);
        req_class   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        req_alu_opr = 4'($urandom_range(0, 10));
        req_sub_op  = 3'($urandom_range(0, 7));
        req_rd      = 5'($urandom_range(0, 31));
        req_rs1     = 5'($urandom_range(0, 31));
        req_rs2     = 5'($urandom_range(0, 31));
        req_imm     = 21'($urandom_range(0, 32'h1fffff));
      end
      bundle_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b0; bundle_ready = 1'b1;
    @(posedge clk); #1;
    pulse_flush();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    check("drain_hold", hold_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
